mem_if_arbiter: RTL and testbench
=================================

// Module: mem_if_arbiter
// PURPOSE
//  Shares one downstream memory interface (mem_req_vld/mem_ack_vld/addr/wr/rd) among REQ_CNT
//  requesters, each a snapshot-memory front end driving the same protocol. Round-robin grant,
//  one transaction in flight, grant held until mem_ack_vld. Sits between the snapshot blocks
//  and the single-ported memory wrapper.
// PARAMETERS
//  REQ_CNT         4             number of requesters (2..16)
//  DATA_WIDTH      64            memory data width
//  ADDR_WIDTH      32            memory address width
//  IDX_WIDTH       log2(REQ_CNT) grant index width (localparam, min 1)
//  TIMEOUT_CYCLES  1024          BUSY cycles without ack before forced completion (macro only)
//  ERR_RD_VALUE    {DATA_WIDTH{1'b1}}  s_rd_data returned on timeout (macro only)
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    reset, asynchronous, active-low
//  soft_rst     in   1                    synchronous soft reset, active-high
//  s_req_vld    in   REQ_CNT              per-requester request, level, held until s_ack_vld
//  s_wr_en      in   REQ_CNT              per-requester write strobe
//  s_rd_en      in   REQ_CNT              per-requester read strobe
//  s_addr       in   REQ_CNT*ADDR_WIDTH   flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  s_wr_data    in   REQ_CNT*DATA_WIDTH   flattened, same packing
//  s_ack_vld    out  REQ_CNT              one-hot completion pulse to granted requester
//  s_rd_data    out  DATA_WIDTH           read data, broadcast, valid with s_ack_vld
//  mem_req_vld  out  1                    downstream request, high throughout BUSY
//  mem_ack_vld  in   1                    downstream completion, single-cycle pulse
//  mem_addr     out  ADDR_WIDTH           muxed from granted requester
//  mem_wr_en    out  1                    muxed, gated by BUSY
//  mem_rd_en    out  1                    muxed, gated by BUSY
//  mem_wr_data  out  DATA_WIDTH           muxed from granted requester
//  mem_rd_data  in   DATA_WIDTH           downstream read data, valid with mem_ack_vld
//  grant_idx    out  IDX_WIDTH            registered index of current/last grant
//  busy         out  1                    state == S_BUSY
//  err_timeout  out  1                    sticky timeout flag (tied 0 without macro)
// BEHAVIOUR
//  - Reset (rst_n low or soft_rst): state S_IDLE, rr pointer 0, grant_idx 0, all outputs 0.
//  - Eligible requester i: s_req_vld[i] & (s_wr_en[i] | s_rd_en[i]).
//  - S_IDLE: any eligible -> pick first eligible at or after rr pointer (wrapping), register
//    grant_idx, next S_BUSY. None eligible -> stay.
//  - S_BUSY: mem_req_vld=1; mem_addr/wr_en/rd_en/wr_data combinationally muxed from grant_idx.
//    On mem_ack_vld: s_ack_vld[grant_idx]=1 same cycle, s_rd_data=mem_rd_data, rr pointer <=
//    grant_idx+1 (wrap to 0 at REQ_CNT), next S_IDLE.
//  - Latency: req seen in IDLE cycle N -> mem_req_vld cycle N+1; ack cycle M -> s_ack_vld cycle
//    M; earliest next grant decision M+1, next mem_req_vld M+2 (one-cycle turnaround).
//  - s_ack_vld and s_rd_data are 0 whenever no completion this cycle.
//  - Granted requester dropping s_req_vld mid-BUSY: transaction still completes, ack issued.
//  - mem_ack_vld while S_IDLE: ignored, no s_ack_vld.
//  - s_wr_en & s_rd_en both set: passed through unchanged; downstream defines precedence.
//  - soft_rst in BUSY: abort, no ack, pointer 0; late mem_ack_vld dropped per above.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: 16-bit counter cleared on IDLE->BUSY, increments in BUSY; on
//   reaching TIMEOUT_CYCLES without ack: s_ack_vld[grant_idx]=1, s_rd_data=ERR_RD_VALUE,
//   err_timeout set (cleared only by reset/soft_rst), pointer advances, next S_IDLE.
//   Ack and expiry in same cycle: ack wins, real data returned, no flag.
//  Not defined: no counter; BUSY waits indefinitely; err_timeout tied 0.
// STRUCTURE
//  - mem_arb_pkg: state enum (S_IDLE, S_BUSY), clog2 helper.
//  - Sub-module rr_arbiter: REQ_CNT eligible vector + pointer -> one-hot grant + index (comb).
//  - Top: FSM, grant/pointer registers, output mux, timeout counter under macro.
// TESTING
//  1 Single: req[2] write addr 0x40 -> mem_req_vld next cycle, mem_addr=0x40; ack -> s_ack_vld=4'b0100.
//  2 RR fairness: req=4'b1111 held, 1-cycle ack -> grant order 0,1,2,3,0; one idle cycle between.
//  3 Read data: req[1] read, ack with mem_rd_data=0xDEAD_BEEF_0123_4567 -> s_rd_data equal, same cycle.
//  4 Stray ack in IDLE and soft_rst mid-BUSY -> no s_ack_vld, pointer 0, next grant req[0].
//  5 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> 8th BUSY cycle s_ack_vld, rd=all-ones, err_timeout=1.
//  6 Pointer wrap: grant req[3] completes, then req=4'b1001 -> req[0] granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-interface arbiter.
// Holds the FSM state encoding and the index-width helper used by the top
// level and the round-robin picker.
package mem_arb_pkg;

  // Arbiter FSM states: waiting for a request, or one transaction in flight.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_e;

  // Bits needed to index n requesters, never less than 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 16; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_if_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Scans the eligible vector starting at the pointer position, wrapping
// around, and returns the first hit as both a one-hot vector and an index.
module rr_arbiter #(
  parameter int REQ_CNT   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [REQ_CNT-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [REQ_CNT-1:0]   gnt_oh,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_vld
);

  // First eligible requester at or after ptr, wrapping at REQ_CNT.
  always_comb begin
    int j;
    j       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < REQ_CNT; k++) begin
      j = int'(ptr) + k;
      if (j >= REQ_CNT) j = j - REQ_CNT;
      if (!gnt_vld && req[j]) begin
        gnt_vld    = 1'b1;
        gnt_idx    = IDX_WIDTH'(j);
        gnt_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_if_arbiter.sv
// mem_if_arbiter: shares one downstream memory port among REQ_CNT requesters.
// Round-robin grant, one transaction in flight, grant held until completion.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that forces
// completion with ERR_RD_VALUE and raises a sticky err_timeout flag.
//
// Handshake: a requester raises s_req_vld together with s_wr_en and/or
// s_rd_en and holds them until it sees its s_ack_vld bit pulse for one cycle;
// downstream, mem_req_vld stays high for the whole transaction and the memory
// answers with a single-cycle mem_ack_vld carrying mem_rd_data.
module mem_if_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REQ_CNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
`ifdef MEM_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_RD_VALUE = {DATA_WIDTH{1'b1}},
`endif
  localparam int IDX_WIDTH = clog2_min1(REQ_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          soft_rst,
  input  logic [REQ_CNT-1:0]            s_req_vld,
  input  logic [REQ_CNT-1:0]            s_wr_en,
  input  logic [REQ_CNT-1:0]            s_rd_en,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0] s_addr,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] s_wr_data,
  output logic [REQ_CNT-1:0]            s_ack_vld,
  output logic [DATA_WIDTH-1:0]         s_rd_data,
  output logic                          mem_req_vld,
  input  logic                          mem_ack_vld,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy,
  output logic                          err_timeout
);

  arb_state_e           state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [REQ_CNT-1:0]   grant_oh;
  logic [REQ_CNT-1:0]   eligible;
  logic [REQ_CNT-1:0]   arb_oh;
  logic [IDX_WIDTH-1:0] arb_idx;
  logic                 arb_vld;
  logic                 ack_fire;
  logic                 tmo_fire;
  logic [IDX_WIDTH-1:0] next_ptr;

  // A requester only competes when it actually asks for a read or write.
  assign eligible = s_req_vld & (s_wr_en | s_rd_en);

  rr_arbiter #(
    .REQ_CNT   (REQ_CNT),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Acks outside BUSY are stray (e.g. after an abort) and are dropped.
  assign ack_fire = (state == S_BUSY) && mem_ack_vld;

  // Pointer moves to the requester just after the one that completed.
  assign next_ptr = (int'(grant_idx) == REQ_CNT - 1) ? '0 : grant_idx + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // Counter holds BUSY cycle number minus one, so expiry lands on the
  // TIMEOUT_CYCLES-th BUSY cycle; a real ack in that cycle takes priority.
  assign tmo_fire = (state == S_BUSY) && !mem_ack_vld &&
                    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Arbiter FSM with grant, pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_oh  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
`endif
    end else if (soft_rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant_oh  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_vld) begin
            state     <= S_BUSY;
            grant_idx <= arb_idx;
            grant_oh  <= arb_oh;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_fire) err_timeout <= 1'b1;
`endif
          if (ack_fire || tmo_fire) begin
            state  <= S_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state == S_BUSY);
  assign mem_req_vld = busy;

  // Downstream request fields come from the granted requester, zero when idle.
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    if (busy) begin
      mem_addr    = s_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wr_data = s_wr_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      mem_wr_en   = s_wr_en[grant_idx];
      mem_rd_en   = s_rd_en[grant_idx];
    end
  end

  // Completion is returned in the same cycle it happens, zero otherwise.
  always_comb begin
    s_ack_vld = (ack_fire || tmo_fire) ? grant_oh : '0;
    s_rd_data = '0;
    if (ack_fire) begin
      s_rd_data = mem_rd_data;
`ifdef MEM_ARB_TIMEOUT_EN
    end else if (tmo_fire) begin
      s_rd_data = ERR_RD_VALUE;
`endif
    end
  end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed bench for mem_if_arbiter (REQ_CNT=4, 64-bit data, 32-bit address).
// A per-cycle vector table covers grant, round-robin order, read data,
// stray/late acks, soft reset, pointer wrap and dropped requests; short
// hand-written sequences cover latency and the optional watchdog.
module tb_mem_if_arbiter;

  localparam int RC = 4;
  localparam int DW = 64;
  localparam int AW = 32;

  logic              clk;
  logic              rst_n;
  logic              soft_rst;
  logic [RC-1:0]     s_req_vld, s_wr_en, s_rd_en;
  logic [RC*AW-1:0]  s_addr;
  logic [RC*DW-1:0]  s_wr_data;
  logic [RC-1:0]     s_ack_vld;
  logic [DW-1:0]     s_rd_data;
  logic              mem_req_vld;
  logic              mem_ack_vld;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en, mem_rd_en;
  logic [DW-1:0]     mem_wr_data;
  logic [DW-1:0]     mem_rd_data;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              err_timeout;

  mem_if_arbiter #(
    .REQ_CNT    (RC),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst    (soft_rst),
    .s_req_vld   (s_req_vld),
    .s_wr_en     (s_wr_en),
    .s_rd_en     (s_rd_en),
    .s_addr      (s_addr),
    .s_wr_data   (s_wr_data),
    .s_ack_vld   (s_ack_vld),
    .s_rd_data   (s_rd_data),
    .mem_req_vld (mem_req_vld),
    .mem_ack_vld (mem_ack_vld),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // Per-cycle vector: inputs applied after a rising edge, outputs checked
  // on the following falling edge.
  typedef struct {
    logic          sr;
    logic [3:0]    req, wr, rd;
    logic          ack;
    logic [63:0]   rdat;
    logic          e_mreq;
    logic [3:0]    e_sack;
    logic [1:0]    e_gidx;
    logic [31:0]   e_addr;
    logic          e_wr, e_rd;
    logic [63:0]   e_rdata;
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] A2 = 32'h0000_0040;
  localparam logic [31:0] A3 = 32'h0000_3000;
  localparam logic [63:0] RDX = 64'hDEAD_BEEF_0123_4567;

  function automatic vec_t mk(input logic sr, input logic [3:0] req, input logic [3:0] wr,
                              input logic [3:0] rd, input logic ack, input logic [63:0] rdat,
                              input logic e_mreq, input logic [3:0] e_sack,
                              input logic [1:0] e_gidx, input logic [31:0] e_addr,
                              input logic e_wr, input logic e_rd, input logic [63:0] e_rdata);
    vec_t v;
    v.sr = sr; v.req = req; v.wr = wr; v.rd = rd; v.ack = ack; v.rdat = rdat;
    v.e_mreq = e_mreq; v.e_sack = e_sack; v.e_gidx = e_gidx; v.e_addr = e_addr;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic sr, input logic [3:0] req, input logic [3:0] wr,
                       input logic [3:0] rd, input logic ack, input logic [63:0] rdat);
    @(posedge clk);
    #1;
    soft_rst    = sr;
    s_req_vld   = req;
    s_wr_en     = wr;
    s_rd_en     = rd;
    mem_ack_vld = ack;
    mem_rd_data = rdat;
  endtask

  initial begin
    int n;
    logic [31:0] atab [4];
    atab[0] = A0; atab[1] = A1; atab[2] = A2; atab[3] = A3;
    for (int i = 0; i < RC; i++) begin
      s_addr[i*AW +: AW]    = atab[i];
      s_wr_data[i*DW +: DW] = 64'h00A0 + 64'(i);
    end

    //           sr  req      wr       rd       ack  rdat            mreq sack     g  addr wr rd rdata
    // single write from requester 2
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 64'h0,         1, 4'b0000, 2, A2, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 64'h0,         1, 4'b0100, 2, A2, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,         0, 4'b0000, 2, 0,  0, 0, 64'h0));
    // read from requester 1, data returned in the ack cycle
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 0, 64'h0,         0, 4'b0000, 2, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, RDX,           1, 4'b0010, 1, A1, 0, 1, RDX));
    // stray ack in IDLE
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'hFFFF,      0, 4'b0000, 1, 0,  0, 0, 64'h0));
    // pointer at 2: requester 3 granted, then aborted by soft reset
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 0, 64'h0,         0, 4'b0000, 1, 0,  0, 0, 64'h0));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b0000, 0, 64'h0,         1, 4'b0000, 3, A3, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h55,        0, 4'b0000, 0, 0,  0, 0, 64'h0));
    // all four requesting: order 0,1,2,3,0 with one idle cycle between
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 64'h1111,      1, 4'b0001, 0, A0, 1, 0, 64'h1111));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 64'h0,         1, 4'b0010, 1, A1, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 64'h0,         0, 4'b0000, 1, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 64'h0,         1, 4'b0100, 2, A2, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 64'h0,         0, 4'b0000, 2, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 64'h0,         1, 4'b1000, 3, A3, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 0, 64'h0,         0, 4'b0000, 3, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 64'h0,         1, 4'b0001, 0, A0, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    // pointer 1, req 1001: 3 first, then wrap to 0
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b0000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b0000, 1, 64'h0,         1, 4'b1000, 3, A3, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b0000, 0, 64'h0,         0, 4'b0000, 3, 0,  0, 0, 64'h0));
    // requester 0 drops its request mid-BUSY; transaction still completes
    vecs.push_back(mk(0, 4'b1000, 4'b1001, 4'b0000, 0, 64'h0,         1, 4'b0000, 0, A0, 1, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1000, 4'b1001, 4'b0000, 1, 64'h0,         1, 4'b0001, 0, A0, 1, 0, 64'h0));
    // write+read together passed through; requester 3 drops before ack
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 64'h0,         0, 4'b0000, 0, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 64'h0,         1, 4'b0000, 3, A3, 1, 1, 64'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 64'h77,        1, 4'b1000, 3, A3, 0, 0, 64'h77));
    // request without any strobe is not eligible
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'h0,         0, 4'b0000, 3, 0,  0, 0, 64'h0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 64'h0,         0, 4'b0000, 3, 0,  0, 0, 64'h0));

    // Reset block
    rst_n = 1'b0; soft_rst = 1'b0;
    s_req_vld = '0; s_wr_en = '0; s_rd_en = '0;
    mem_ack_vld = 1'b0; mem_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset mem_req_vld", 64'(mem_req_vld), 64'd0);
    chk("reset busy",        64'(busy),        64'd0);
    chk("reset grant_idx",   64'(grant_idx),   64'd0);
    chk("reset s_ack_vld",   64'(s_ack_vld),   64'd0);
    chk("reset mem_addr",    64'(mem_addr),    64'd0);
    chk("reset err_timeout", 64'(err_timeout), 64'd0);
    rst_n = 1'b1;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.sr, v.req, v.wr, v.rd, v.ack, v.rdat);
      @(negedge clk);
      chk($sformatf("v%0d mem_req_vld", i), 64'(mem_req_vld), 64'(v.e_mreq));
      chk($sformatf("v%0d busy", i),        64'(busy),        64'(v.e_mreq));
      chk($sformatf("v%0d s_ack_vld", i),   64'(s_ack_vld),   64'(v.e_sack));
      chk($sformatf("v%0d grant_idx", i),   64'(grant_idx),   64'(v.e_gidx));
      chk($sformatf("v%0d mem_addr", i),    64'(mem_addr),    64'(v.e_addr));
      chk($sformatf("v%0d mem_wr_en", i),   64'(mem_wr_en),   64'(v.e_wr));
      chk($sformatf("v%0d mem_rd_en", i),   64'(mem_rd_en),   64'(v.e_rd));
      chk($sformatf("v%0d s_rd_data", i),   s_rd_data,        v.e_rdata);
    end

    // Latency and multi-cycle hold: requester 1 write, ack after 4 BUSY cycles
    drive(0, 4'b0010, 4'b0010, 4'b0000, 0, 64'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req_vld && n < 5);
    chk("lat req-to-mem_req_vld cycles", 64'(n), 64'd2);
    chk("lat mem_wr_data", mem_wr_data, 64'h00A1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'b0010, 4'b0010, 4'b0000, 0, 64'h0);
      @(negedge clk);
      chk($sformatf("hold%0d mem_req_vld", k), 64'(mem_req_vld), 64'd1);
      chk($sformatf("hold%0d s_ack_vld", k),   64'(s_ack_vld),   64'd0);
    end
    drive(0, 4'b0010, 4'b0010, 4'b0000, 1, 64'h0);
    @(negedge clk);
    chk("lat ack s_ack_vld", 64'(s_ack_vld), 64'b0010);
    drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0);
    @(negedge clk);
    chk("lat after ack busy", 64'(busy), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: requester 2 write, memory never answers
    drive(0, 4'b0100, 4'b0100, 4'b0000, 0, 64'h0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 4'b0100, 4'b0100, 4'b0000, 0, 64'h0);
      @(negedge clk);
      if (k < 8) begin
        chk($sformatf("tmo cyc%0d s_ack_vld", k), 64'(s_ack_vld), 64'd0);
      end else begin
        chk("tmo expire s_ack_vld", 64'(s_ack_vld), 64'b0100);
        chk("tmo expire s_rd_data", s_rd_data, {64{1'b1}});
      end
    end
    drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0);
    @(negedge clk);
    chk("tmo err_timeout", 64'(err_timeout), 64'd1);
    chk("tmo busy",        64'(busy),        64'd0);
`else
    chk("err_timeout tied low", 64'(err_timeout), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
